// File: rtl/isa_pkg.sv
// Shared ISA definitions for the core decoder and the program memory loader.
// Holds opcode and register encodings, the NOP fill word and the loader state type.
package isa_pkg;

    localparam int OPCODE_W = 4;
    localparam int REG_W    = 2;
    localparam int WORD_W   = OPCODE_W + REG_W;

    localparam logic [OPCODE_W-1:0] OPCODE_NOP = 4'h0;
    localparam logic [OPCODE_W-1:0] OPCODE_ADD = 4'h1;
    localparam logic [OPCODE_W-1:0] OPCODE_SUB = 4'h2;
    localparam logic [OPCODE_W-1:0] OPCODE_AND = 4'h3;
    localparam logic [OPCODE_W-1:0] OPCODE_OR  = 4'h4;
    localparam logic [OPCODE_W-1:0] OPCODE_XOR = 4'h5;
    localparam logic [OPCODE_W-1:0] OPCODE_NOT = 4'h6;
    localparam logic [OPCODE_W-1:0] OPCODE_LD  = 4'h7;
    localparam logic [OPCODE_W-1:0] OPCODE_ST  = 4'h8;

    localparam logic [REG_W-1:0] R0 = 2'd0;
    localparam logic [REG_W-1:0] R1 = 2'd1;
    localparam logic [REG_W-1:0] R2 = 2'd2;
    localparam logic [REG_W-1:0] R3 = 2'd3;

    localparam logic [WORD_W-1:0] NOP_WORD = {OPCODE_NOP, R0};

    typedef enum logic [1:0] {
        FILL = 2'd0,
        RUN  = 2'd1,
        LOAD = 2'd2
    } ldr_state_t;

endpackage

// File: rtl/program_memory_loader_if.sv
// Fetch port and loader stream port of the program memory loader.
// master = core/loader side, slave = program_memory_loader.
interface program_memory_loader_if #(
    parameter int ADDR_W  = 5,
    parameter int INSTR_W = 6
);
    import isa_pkg::*;

    logic               fetch_en;
    logic [ADDR_W-1:0]  fetch_addr;
    logic [INSTR_W-1:0] instr_out;
    logic               instr_valid;
    logic               hold_cpu;
    logic               load_start;
    logic               ld_valid;
    logic [INSTR_W-1:0] ld_data;
    logic               ld_last;
    logic               ld_ready;
    logic               load_done;
    logic [ADDR_W:0]    words_loaded;

    modport master (
        output fetch_en, fetch_addr, load_start, ld_valid, ld_data, ld_last,
        input  instr_out, instr_valid, hold_cpu, ld_ready, load_done, words_loaded
    );

    modport slave (
        input  fetch_en, fetch_addr, load_start, ld_valid, ld_data, ld_last,
        output instr_out, instr_valid, hold_cpu, ld_ready, load_done, words_loaded
    );

endinterface

// File: rtl/program_memory_loader_ram.sv
// DEPTH x INSTR_W instruction store: one write port, one registered read port.
// The array itself is never reset; only the read register is.
module prog_mem_ram #(
    parameter int                 ADDR_W   = 5,
    parameter int                 INSTR_W  = 6,
    parameter logic [INSTR_W-1:0] RST_WORD = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [INSTR_W-1:0] wr_data,
    input  logic               rd_en,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [INSTR_W-1:0] rd_data
);
    import isa_pkg::*;

    localparam int DEPTH = 1 << ADDR_W;

    logic [INSTR_W-1:0] mem_q [DEPTH];
    logic [INSTR_W-1:0] rd_data_d, rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= RST_WORD;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/program_memory_loader.sv
// Reloadable instruction memory: serves core fetches in RUN, accepts a program over
// a valid/ready stream in LOAD, and scrubs the unused tail with NOPs in FILL.
module program_memory_loader #(
    parameter int                 ADDR_W   = 5,
    parameter int                 INSTR_W  = 6,
    parameter logic [INSTR_W-1:0] NOP_WORD = INSTR_W'(isa_pkg::NOP_WORD)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    program_memory_loader_if.slave  bus
);
    import isa_pkg::*;

    localparam int                DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    ldr_state_t         state_d, state_q;
    logic [ADDR_W-1:0]  ptr_d, ptr_q;
    logic [ADDR_W:0]    words_loaded_d, words_loaded_q;
    logic               instr_valid_d, instr_valid_q;
    logic               hold_cpu_d, hold_cpu_q;
    logic               ld_ready_d, ld_ready_q;
    logic               load_done_d, load_done_q;
    logic               post_load_d, post_load_q;

    logic               wr_en;
    logic [INSTR_W-1:0] wr_data;
    logic               rd_en;
    logic               handshake;

    assign handshake = bus.ld_valid && ld_ready_q;

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        words_loaded_d = words_loaded_q;
        instr_valid_d  = 1'b0;
        load_done_d    = 1'b0;
        post_load_d    = post_load_q;
        wr_en          = 1'b0;
        wr_data        = NOP_WORD;
        rd_en          = 1'b0;

        case (state_q)
            FILL: begin
                wr_en = 1'b1;
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == LAST) begin
                    // Only a scrub that follows a reload reports completion.
                    state_d     = RUN;
                    load_done_d = post_load_q;
                    post_load_d = 1'b0;
                end
            end
            RUN: begin
                rd_en         = bus.fetch_en;
                instr_valid_d = bus.fetch_en;
                if (bus.load_start) begin
                    state_d        = LOAD;
                    ptr_d          = '0;
                    words_loaded_d = '0;
                end
            end
            LOAD: begin
                if (handshake) begin
                    wr_en          = 1'b1;
                    wr_data        = bus.ld_data;
                    words_loaded_d = words_loaded_q + 1'b1;
                    ptr_d          = ptr_q + 1'b1;
                    if (ptr_q == LAST) begin
                        // Memory is full, so there is no tail left to scrub.
                        state_d     = RUN;
                        load_done_d = 1'b1;
                    end else if (bus.ld_last) begin
                        state_d     = FILL;
                        post_load_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = FILL;
                ptr_d   = '0;
            end
        endcase

        hold_cpu_d = (state_d != RUN);
        ld_ready_d = (state_d == LOAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= FILL;
            ptr_q          <= '0;
            words_loaded_q <= '0;
            instr_valid_q  <= 1'b0;
            hold_cpu_q     <= 1'b1;
            ld_ready_q     <= 1'b0;
            load_done_q    <= 1'b0;
            post_load_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            words_loaded_q <= words_loaded_d;
            instr_valid_q  <= instr_valid_d;
            hold_cpu_q     <= hold_cpu_d;
            ld_ready_q     <= ld_ready_d;
            load_done_q    <= load_done_d;
            post_load_q    <= post_load_d;
        end
    end

    prog_mem_ram #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .RST_WORD (NOP_WORD)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (ptr_q),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (bus.fetch_addr),
        .rd_data (bus.instr_out)
    );

    assign bus.instr_valid  = instr_valid_q;
    assign bus.hold_cpu     = hold_cpu_q;
    assign bus.ld_ready     = ld_ready_q;
    assign bus.load_done    = load_done_q;
    assign bus.words_loaded = words_loaded_q;

endmodule

// File: tb/tb_program_memory_loader.sv
// Directed bench for program_memory_loader: scrub after reset, reloads of various
// lengths, stalled handshakes, reset during load and load_start corner cases.
module tb_program_memory_loader;
    import isa_pkg::*;

    localparam int ADDR_W  = 5;
    localparam int INSTR_W = 6;

    localparam logic [5:0] W_NOP   = 6'h00;
    localparam logic [5:0] W_ADDR1 = {OPCODE_ADD, R1};
    localparam logic [5:0] W_SUBR1 = {OPCODE_SUB, R1};
    localparam logic [5:0] W_STR3  = {OPCODE_ST, R3};
    localparam logic [5:0] W_LDR2  = {OPCODE_LD, R2};
    localparam logic [5:0] W_XORR0 = {OPCODE_XOR, R0};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    program_memory_loader_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

    program_memory_loader #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [5:0] data, input logic last);
        bus.ld_valid = 1'b1;
        bus.ld_data  = data;
        bus.ld_last  = last;
        tick();
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
    endtask

    task automatic fetch(input string tag, input logic [4:0] addr, input logic [5:0] exp);
        bus.fetch_en   = 1'b1;
        bus.fetch_addr = addr;
        tick();
        bus.fetch_en   = 1'b0;
        chk({tag, "_valid"}, 32'(bus.instr_valid), 32'd1);
        chk({tag, "_data"}, 32'(bus.instr_out), 32'(exp));
    endtask

    task automatic start_load();
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (bus.load_done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_run(output int n, output int dones);
        n = 0;
        dones = 0;
        while (bus.hold_cpu === 1'b1 && n < 200) begin
            tick();
            n++;
            if (bus.load_done === 1'b1) dones++;
        end
    endtask

    initial begin
        int n;
        int dones;
        bus.fetch_en   = 1'b0;
        bus.fetch_addr = '0;
        bus.load_start = 1'b0;
        bus.ld_valid   = 1'b0;
        bus.ld_data    = '0;
        bus.ld_last    = 1'b0;

        // 1: reset values, post-reset scrub, fetch everything
        tick();
        tick();
        chk("rst_hold", 32'(bus.hold_cpu), 32'd1);
        chk("rst_instr", 32'(bus.instr_out), 32'(W_NOP));
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_ready", 32'(bus.ld_ready), 32'd0);
        chk("rst_done", 32'(bus.load_done), 32'd0);
        chk("rst_words", 32'(bus.words_loaded), 32'd0);
        rst_n = 1'b1;
        wait_run(n, dones);
        chk("fill_cycles", 32'(n), 32'd32);
        chk("fill_no_done", 32'(dones), 32'd0);
        for (int a = 0; a < 32; a++) begin
            fetch("t1_fetch", 5'(a), W_NOP);
        end
        tick();
        chk("t1_idle_valid", 32'(bus.instr_valid), 32'd0);

        // 2: three-word program with ld_last on the third word
        start_load();
        chk("t2_ready", 32'(bus.ld_ready), 32'd1);
        chk("t2_hold", 32'(bus.hold_cpu), 32'd1);
        chk("t2_words0", 32'(bus.words_loaded), 32'd0);
        send(W_ADDR1, 1'b0);
        send(W_SUBR1, 1'b0);
        send(W_STR3, 1'b1);
        chk("t2_words", 32'(bus.words_loaded), 32'd3);
        chk("t2_ready_off", 32'(bus.ld_ready), 32'd0);
        wait_done(n);
        chk("t2_fill_cycles", 32'(n), 32'd29);
        chk("t2_hold_off", 32'(bus.hold_cpu), 32'd0);
        tick();
        chk("t2_done_pulse", 32'(bus.load_done), 32'd0);
        fetch("t2_f0", 5'd0, W_ADDR1);
        fetch("t2_f1", 5'd1, W_SUBR1);
        fetch("t2_f2", 5'd2, W_STR3);
        fetch("t2_f3", 5'd3, W_NOP);
        fetch("t2_f31", 5'd31, W_NOP);

        // 3: full load, ld_last never asserted
        start_load();
        for (int i = 0; i < 32; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = 6'(i) ^ 6'h2A;
            bus.ld_last  = 1'b0;
            tick();
        end
        bus.ld_valid = 1'b0;
        chk("t3_done", 32'(bus.load_done), 32'd1);
        chk("t3_words", 32'(bus.words_loaded), 32'd32);
        chk("t3_hold", 32'(bus.hold_cpu), 32'd0);
        chk("t3_ready", 32'(bus.ld_ready), 32'd0);
        fetch("t3_f31", 5'd31, 6'h35);
        fetch("t3_f0", 5'd0, 6'h2A);
        fetch("t3_f17", 5'd17, 6'h3B);

        // 4: gapped handshakes, fetch ignored in LOAD, tail rescrubbed
        start_load();
        bus.fetch_en   = 1'b1;
        bus.fetch_addr = 5'd0;
        send(W_LDR2, 1'b0);
        chk("t4_words1", 32'(bus.words_loaded), 32'd1);
        chk("t4_load_fetch", 32'(bus.instr_valid), 32'd0);
        tick();
        chk("t4_idle_words", 32'(bus.words_loaded), 32'd1);
        tick();
        chk("t4_idle_words2", 32'(bus.words_loaded), 32'd1);
        chk("t4_load_fetch2", 32'(bus.instr_valid), 32'd0);
        send(W_XORR0, 1'b1);
        bus.fetch_en = 1'b0;
        chk("t4_words2", 32'(bus.words_loaded), 32'd2);
        wait_done(n);
        chk("t4_fill_cycles", 32'(n), 32'd30);
        fetch("t4_f2", 5'd2, W_NOP);
        fetch("t4_f0", 5'd0, W_LDR2);
        fetch("t4_f1", 5'd1, W_XORR0);

        // 5: reset in the middle of a load
        start_load();
        for (int i = 0; i < 5; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = W_STR3;
            tick();
        end
        bus.ld_valid = 1'b0;
        chk("t5_words5", 32'(bus.words_loaded), 32'd5);
        rst_n = 1'b0;
        #1;
        chk("t5_hold", 32'(bus.hold_cpu), 32'd1);
        chk("t5_ready", 32'(bus.ld_ready), 32'd0);
        chk("t5_words", 32'(bus.words_loaded), 32'd0);
        chk("t5_instr", 32'(bus.instr_out), 32'(W_NOP));
        #2;
        rst_n = 1'b1;
        wait_run(n, dones);
        chk("t5_fill_cycles", 32'(n), 32'd32);
        chk("t5_no_done", 32'(dones), 32'd0);
        for (int a = 0; a < 5; a++) begin
            fetch("t5_fetch", 5'(a), W_NOP);
        end

        // 6: load_start together with a fetch, then a stray load_start in LOAD
        bus.fetch_en   = 1'b1;
        bus.fetch_addr = 5'd4;
        bus.load_start = 1'b1;
        tick();
        bus.fetch_en   = 1'b0;
        bus.load_start = 1'b0;
        chk("t6_valid", 32'(bus.instr_valid), 32'd1);
        chk("t6_ready", 32'(bus.ld_ready), 32'd1);
        send(W_ADDR1, 1'b0);
        send(W_SUBR1, 1'b0);
        start_load();
        chk("t6_stray_words", 32'(bus.words_loaded), 32'd2);
        chk("t6_stray_ready", 32'(bus.ld_ready), 32'd1);
        send(W_STR3, 1'b1);
        chk("t6_words", 32'(bus.words_loaded), 32'd3);
        wait_done(n);
        chk("t6_done", 32'(bus.load_done), 32'd1);
        fetch("t6_f0", 5'd0, W_ADDR1);
        fetch("t6_f2", 5'd2, W_STR3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/program_memory_loader.md
Name: program_memory_loader

Overview:
Parametrised successor to the fixed 32x6 instruction ROM. It holds DEPTH instruction words and serves the core's fetch port with a registered one-cycle read. A valid/ready stream port lets the program be reloaded at run time. After reset, and after every load, the unused tail is scrubbed with NOP words, and the core is held while the memory is not coherent.

Parameters:
ADDR_W, 5, address width; DEPTH = 2**ADDR_W words
INSTR_W, 6, instruction word width (opcode + register field)
NOP_WORD, isa_pkg::NOP_WORD ({OPCODE_NOP, R0}), fill value for scrubbed locations

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
fetch_en  in  1  core requests the word at fetch_addr
fetch_addr  in  ADDR_W  fetch address (PC)
instr_out  out  INSTR_W  registered instruction word
instr_valid  out  1  instr_out holds the result of the previous cycle's fetch
hold_cpu  out  1  high while not in RUN; core must stall
load_start  in  1  one-cycle pulse, honoured in RUN only, to begin a reload at address 0
ld_valid  in  1  loader word valid
ld_data  in  INSTR_W  loader word
ld_last  in  1  marks the final word of the program
ld_ready  out  1  block accepts a loader word
load_done  out  1  one-cycle pulse when reload and tail scrub are complete
words_loaded  out  ADDR_W+1  count of words written by the last load, 0..DEPTH

Behaviour:
- Async reset (rst_n=0): state=FILL, ptr=0, instr_out=NOP_WORD, instr_valid=0, ld_ready=0, load_done=0, words_loaded=0, hold_cpu=1. Memory contents are not reset directly; FILL overwrites them.
- FILL: write NOP_WORD to Mem[ptr] each cycle and increment ptr. At ptr==DEPTH-1, write that word and go to RUN.
  - A post-reset FILL takes DEPTH cycles (32 by default) and raises no load_done.
  - A post-load FILL pulses load_done in the cycle it enters RUN.
- RUN: hold_cpu=0, ld_ready=0.
  - fetch_en=1 in cycle N gives instr_out=Mem[fetch_addr] and instr_valid=1 in cycle N+1.
  - fetch_en=0 gives instr_valid=0 next cycle; instr_out holds its last value.
- load_start in RUN:
  - A fetch in the same cycle is still served (valid in N+1).
  - Next state is LOAD with ptr=0 and words_loaded=0. load_start outside RUN is ignored.
- LOAD: hold_cpu=1, ld_ready=1, fetches ignored, instr_valid=0.
  - On a handshake (ld_valid and ld_ready), Mem[ptr]=ld_data, ptr++, words_loaded++.
  - Handshake with ld_last=1 and ptr<DEPTH-1: go to FILL at ptr+1, then ld_ready=0 from the next cycle.
  - Handshake with ptr==DEPTH-1, regardless of ld_last: the memory is full. Skip FILL, go to RUN, pulse load_done, words_loaded=DEPTH. ptr wraps to 0 and is never used beyond.
  - ld_valid=0 idles with no timeout; state is held indefinitely.
- Writes and reads never address the same word in the same cycle, because fetch is served only in RUN. No bypass logic is required.
- Reset mid-FILL or mid-LOAD: immediate abort; restart FILL from 0; words_loaded=0. Partially loaded words are scrubbed.
- instr_out is updated only by served fetches. Leaving RUN does not alter it.

Decomposition:
- isa_pkg (shared, used by the core decoder and this block) holds:
  - OPCODE_W=4 and REG_W=2
  - opcodes OPCODE_NOP/ADD/SUB/AND/OR/XOR/NOT/LD/ST
  - register codes R0..R3
  - NOP_WORD
  - the state enum ldr_state_t {FILL, RUN, LOAD}
- Sub-module prog_mem_ram: a DEPTH x INSTR_W array with one write port and a registered read port, no reset on the array. The FSM, pointer, counters and handshake stay in program_memory_loader.

Test Plan:
1. Reset release, no stimulus -> hold_cpu=1 for exactly 32 cycles, no load_done. Then every fetch of addresses 0..31 returns NOP_WORD with instr_valid one cycle after fetch_en.
2. Reload of 3 words {ADD,R1},{SUB,R1},{ST,R3} with ld_last on the third:
   - load_done pulses after 3 handshakes plus 29 FILL cycles; words_loaded=3.
   - Fetch 0/1/2 returns those words; fetch 3 and 31 return NOP_WORD.
3. Full 32-word load with ld_last never asserted -> after the 32nd handshake, RUN entered immediately with a load_done pulse, words_loaded=32, and Mem[31] readable.
4. ld_valid toggled 1,0,0,1 during LOAD -> only 2 words written and words_loaded increments only on handshakes. A fetch_en asserted in LOAD yields instr_valid=0.
5. rst_n dropped after 5 load handshakes -> outputs return to reset values at once; after the 32-cycle FILL, fetch 0..4 returns NOP_WORD.
6. load_start and fetch_en in the same RUN cycle -> fetched word valid next cycle and ld_ready=1 next cycle. A second load_start during LOAD has no effect.
